reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the design's staged resets from the 24 MHz PLL clock and its `locked` flag. It sits directly downstream of the PLL and holds all downstream logic in reset until the PLL has been continuously locked for a programmable time. It then releases up to `NUM_STAGES` reset domains in order, at fixed spacing. It re-asserts every stage on any loss of lock and keeps a saturating count of lock-loss events.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronized-locked cycles required before release; minimum 1.
- `STAGE_GAP_CYCLES`, default 16: number of cycles between successive stage releases; minimum 1.
- `NUM_STAGES`, default 3: number of reset domains; 1..8.

Ports:
- `clock` in 1: 24 MHz PLL output clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock status; asynchronous to `clock`.
- `clear_count` in 1: synchronous pulse that zeroes `lock_loss_count`.
- `stage_reset_n` out `NUM_STAGES`: active-low per-domain resets; bit 0 releases first.
- `ready` out 1: high while all stages are released.
- `lock_loss_count` out 8: saturating count of lock losses.
- `state` out 2: current FSM state, for debug.

## Operation
- Reset values (`reset_n` low, asynchronous): `stage_reset_n`=0, `ready`=0, `lock_loss_count`=0, `state`=WAIT_LOCK, synchronizer flops=0.
- `pll_locked` passes through a 2-flop synchronizer; the synchronizer output is `lock_sync`.
- FSM states and transitions:
  - WAIT_LOCK (0): all stages in reset. When `lock_sync`=1, go to STABILIZE with `stable_cnt`=1.
  - STABILIZE (1): `stable_cnt` increments each cycle `lock_sync`=1. When `stable_cnt`==`LOCK_STABLE_CYCLES` and `lock_sync`=1, go to RELEASE, set `stage_reset_n[0]`=1, and clear `gap_cnt`. `lock_sync`=0 returns to WAIT_LOCK; this is not counted as a loss.
  - RELEASE (2): `gap_cnt` counts to `STAGE_GAP_CYCLES`. Each time it expires, release the next stage and clear `gap_cnt`. Releasing the last stage also sets `ready`=1 and moves to RUN.
  - RUN (3): hold all stages released.
- Lock loss: `lock_sync`=0 while in RELEASE or RUN. On the next edge, all `stage_reset_n` go to 0, `ready` goes to 0, state goes to WAIT_LOCK, and `lock_loss_count` increments.
- `NUM_STAGES`=1: stage 0 release sets `ready` and enters RUN on the same edge.
- Counter rules:
  - `stable_cnt` width is `$clog2(LOCK_STABLE_CYCLES+1)`.
  - `gap_cnt` width is `$clog2(STAGE_GAP_CYCLES+1)`.
  - Neither counter ever wraps.
  - `lock_loss_count` saturates at 255.
- Simultaneous `clear_count` and a loss event: the count becomes 1. The event is never dropped.
- Stage releases are registered and deassert synchronously to `clock`. Assertion on `reset_n` is asynchronous.

## Timing
- `pll_locked` held high from before edge 1, with no losses:
  - `stage_reset_n[0]` rises at edge `LOCK_STABLE_CYCLES`+2.
  - Stage k rises at edge `LOCK_STABLE_CYCLES`+2+k·`STAGE_GAP_CYCLES`.
  - `ready` rises on the same edge as the last stage.
- `pll_locked` first sampled low at edge n: `lock_sync`=0 after edge n+1; resets, `ready`, and the count update take effect at edge n+2.
- `clear_count` sampled at edge n: count reads 0 after edge n.
- `state` is registered and reflects the state after each edge.

## Structure
- Package `reset_seq_pkg`: state enum (WAIT_LOCK, STABILIZE, RELEASE, RUN), `LOSS_CNT_W`=8, `LOSS_CNT_MAX`=255.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with asynchronous active-low clear, instantiated for `pll_locked`.
- All FSM, counter, and output registers live in `reset_sequencer`.

## Test plan
All scenarios use `LOCK_STABLE_CYCLES`=8, `STAGE_GAP_CYCLES`=4, `NUM_STAGES`=3.
- Clean lock: `pll_locked`=1 from edge 1. Stage 0 rises at edge 10, stage 1 at 14, stage 2 and `ready` at 18; `lock_loss_count`=0.
- Glitch during STABILIZE: `pll_locked` low for 1 cycle at edge 6. No release before the glitch plus a full 8-cycle restart; count stays 0.
- Loss in RUN: `pll_locked` drops at edge 30. All `stage_reset_n`=0 and `ready`=0 at edge 32; count=1; the full sequence replays after relock.
- Loss mid-RELEASE: drop after stage 0 releases, before stage 1. Stage 0 re-asserts 2 edges later; stage 1 never releases; count=1.
- Saturation and clear: 256 loss events give count=255. A clear coinciding with a loss gives count=1; a clear alone gives 0.
- Asynchronous reset mid-RUN: `reset_n` low between edges. All outputs are 0 immediately, without waiting for an edge; on release, the full sequence runs from WAIT_LOCK.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    // Next lock-loss count. A loss coinciding with a clear still records the
    // loss, so the count restarts at one rather than dropping the event.
    function automatic logic [LOSS_CNT_W-1:0] loss_count_next(
        input logic [LOSS_CNT_W-1:0] cur,
        input logic                  loss,
        input logic                  clr
    );
        logic [LOSS_CNT_W-1:0] res;
        res = cur;
        if (loss) begin
            if (clr) begin
                res = LOSS_CNT_W'(1);
            end else if (cur != LOSS_CNT_MAX) begin
                res = cur + LOSS_CNT_W'(1);
            end
        end else if (clr) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, one independent chain per bit, with an
// asynchronous active-low clear.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        // Two back-to-back flops give the first one a full cycle to resolve.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                meta_reg[gi] <= 1'b0;
                sync_reg[gi] <= 1'b0;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Holds downstream logic in reset until the PLL has been stably locked, then
// releases the reset domains one by one at a fixed spacing. Any loss of lock
// after release starts re-asserts every domain and is counted.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int NUM_STAGES         = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  clear_count,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [1:0]            state
);

    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GAP_W    = $clog2(STAGE_GAP_CYCLES + 1);

    localparam logic [STABLE_W-1:0]   STABLE_ONE   = STABLE_W'(1);
    localparam logic [STABLE_W-1:0]   STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [GAP_W-1:0]      GAP_ONE      = GAP_W'(1);
    localparam logic [GAP_W-1:0]      GAP_LAST     = GAP_W'(STAGE_GAP_CYCLES);
    localparam logic [NUM_STAGES-1:0] STAGE_FIRST  = NUM_STAGES'(1);
    localparam logic [NUM_STAGES-1:0] ALL_RELEASED = '1;

    logic lock_sync;

    seq_state_t            state_reg,  state_next;
    logic [STABLE_W-1:0]   stable_reg, stable_next;
    logic [GAP_W-1:0]      gap_reg,    gap_next;
    logic [NUM_STAGES-1:0] stage_reg,  stage_next;
    logic                  ready_reg,  ready_next;
    logic [LOSS_CNT_W-1:0] loss_reg,   loss_next;
    logic                  loss_event;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_sync)
    );

    // State, counters and all outputs are registered; reset asserts them at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= WAIT_LOCK;
            stable_reg <= '0;
            gap_reg    <= '0;
            stage_reg  <= '0;
            ready_reg  <= 1'b0;
            loss_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            stable_reg <= stable_next;
            gap_reg    <= gap_next;
            stage_reg  <= stage_next;
            ready_reg  <= ready_next;
            loss_reg   <= loss_next;
        end
    end

    // Sequencing: a counter "expires" on the edge where it would reach its
    // terminal value, so stage 0 releases LOCK_STABLE_CYCLES edges after the
    // first locked sample and stages follow every STAGE_GAP_CYCLES edges.
    always_comb begin
        state_next  = state_reg;
        stable_next = stable_reg;
        gap_next    = gap_reg;
        stage_next  = stage_reg;
        ready_next  = ready_reg;
        loss_event  = 1'b0;

        case (state_reg)
            WAIT_LOCK: begin
                stage_next  = '0;
                ready_next  = 1'b0;
                stable_next = '0;
                if (lock_sync) begin
                    if (STABLE_ONE == STABLE_LAST) begin
                        state_next = RELEASE;
                        stage_next = STAGE_FIRST;
                        gap_next   = '0;
                    end else begin
                        state_next  = STABILIZE;
                        stable_next = STABLE_ONE;
                    end
                end
            end
            STABILIZE: begin
                if (!lock_sync) begin
                    // Lock never reached the release point: not a loss.
                    state_next  = WAIT_LOCK;
                    stable_next = '0;
                end else if (stable_reg + STABLE_ONE == STABLE_LAST) begin
                    state_next  = RELEASE;
                    stable_next = '0;
                    stage_next  = STAGE_FIRST;
                    gap_next    = '0;
                end else begin
                    stable_next = stable_reg + STABLE_ONE;
                end
            end
            RELEASE: begin
                if (!lock_sync) begin
                    loss_event = 1'b1;
                end else if (gap_reg + GAP_ONE == GAP_LAST) begin
                    stage_next = (stage_reg << 1) | STAGE_FIRST;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GAP_ONE;
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase

        // Releasing the last stage (including stage 0 when it is the only
        // one) completes the sequence on the same edge.
        if (state_next == RELEASE && stage_next == ALL_RELEASED) begin
            state_next = RUN;
            ready_next = 1'b1;
        end

        if (loss_event) begin
            state_next  = WAIT_LOCK;
            stage_next  = '0;
            ready_next  = 1'b0;
            gap_next    = '0;
            stable_next = '0;
        end

        loss_next = loss_count_next(loss_reg, loss_event, clear_count);
    end

    assign stage_reset_n   = stage_reg;
    assign ready           = ready_reg;
    assign lock_loss_count = loss_reg;
    assign state           = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected observations are queued by
// edge number when stimulus is scheduled and compared at the falling edge.
module tb_reset_sequencer;

    localparam int L = 8;
    localparam int G = 4;
    localparam int N = 3;

    localparam int ST_WAIT = 0;
    localparam int ST_STAB = 1;
    localparam int ST_REL  = 2;
    localparam int ST_RUN  = 3;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         pll_locked = 1'b0;
    logic         clear_count = 1'b0;
    logic [N-1:0] stage_reset_n;
    logic         ready;
    logic [7:0]   lock_loss_count;
    logic [1:0]   state;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP_CYCLES   (G),
        .NUM_STAGES         (N)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .clear_count     (clear_count),
        .stage_reset_n   (stage_reset_n),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    always #5 clock = ~clock;

    // Edge number since reset release: value k means edge k has occurred.
    int cyc;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int         at;
        logic [2:0] stg;
        logic       rdy;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    endtask

    task automatic push_exp(input int at, input int stg, input int rdy, input int cnt, input int st);
        exp_t e;
        int   idx;
        e.at  = at;
        e.stg = 3'(stg);
        e.rdy = 1'(rdy);
        e.cnt = 8'(cnt);
        e.st  = 2'(st);
        idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, e);
    endtask

    // Lock first sampled high at edge r: expected release sequence.
    task automatic push_sequence(input int r, input int cnt);
        push_exp(r + L,             3'b000, 0, cnt, ST_STAB);
        push_exp(r + L + 1,         3'b001, 0, cnt, ST_REL);
        push_exp(r + L + G,         3'b001, 0, cnt, ST_REL);
        push_exp(r + L + 1 + G,     3'b011, 0, cnt, ST_REL);
        push_exp(r + L + 2 * G,     3'b011, 0, cnt, ST_REL);
        push_exp(r + L + 1 + 2 * G, 3'b111, 1, cnt, ST_RUN);
    endtask

    task automatic sb_service();
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            if (e.at < cyc) check_val($sformatf("c%0d_late", e.at), 32'(cyc), 32'(e.at));
            check_val($sformatf("c%0d_stage", e.at), 32'(stage_reset_n),   32'(e.stg));
            check_val($sformatf("c%0d_ready", e.at), 32'(ready),           32'(e.rdy));
            check_val($sformatf("c%0d_count", e.at), 32'(lock_loss_count), 32'(e.cnt));
            check_val($sformatf("c%0d_state", e.at), 32'(state),           32'(e.st));
            $display("edge %0d: stage=%b ready=%b count=%0d state=%0d",
                     cyc, stage_reset_n, ready, lock_loss_count, state);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (reset_n) sb_service();
    endtask

    task automatic wait_until(input int e);
        int guard = 0;
        while (cyc < e && guard < 4000) begin
            tick();
            guard++;
        end
    endtask

    // Drive pll_locked so that edge e is the first edge to sample val.
    task automatic drive_at(input int e, input logic val);
        int guard = 0;
        while (cyc < e - 1 && guard < 4000) begin
            tick();
            guard++;
        end
        if (cyc != e - 1) check_val("drive_sync", 32'(cyc), 32'(e - 1));
        pll_locked = val;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_reset(input logic lock_level);
        tick();
        reset_n     = 1'b0;
        pll_locked  = lock_level;
        clear_count = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;

        // Reset state
        pll_locked = 1'b1;
        #12;
        check_val("rst_stage", 32'(stage_reset_n),   32'd0);
        check_val("rst_ready", 32'(ready),           32'd0);
        check_val("rst_count", 32'(lock_loss_count), 32'd0);
        check_val("rst_state", 32'(state),           32'(ST_WAIT));

        // Clean lock, then loss in RUN and full replay after relock
        do_reset(1'b1);
        push_exp(2, 3'b000, 0, 0, ST_WAIT);
        push_exp(3, 3'b000, 0, 0, ST_STAB);
        push_sequence(1, 0);
        push_exp(31, 3'b111, 1, 0, ST_RUN);
        push_exp(32, 3'b000, 0, 1, ST_WAIT);
        push_exp(33, 3'b000, 0, 1, ST_WAIT);
        push_sequence(34, 1);
        drive_at(30, 1'b0);
        drive_at(34, 1'b1);
        wait_until(55);
        drain();

        // Asynchronous reset between edges while in RUN
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_stage", 32'(stage_reset_n),   32'd0);
        check_val("async_ready", 32'(ready),           32'd0);
        check_val("async_count", 32'(lock_loss_count), 32'd0);
        check_val("async_state", 32'(state),           32'(ST_WAIT));
        tick();
        reset_n = 1'b1;
        push_sequence(1, 0);
        wait_until(20);
        drain();

        // One-cycle glitch during STABILIZE restarts the lock timer
        do_reset(1'b1);
        push_exp(7, 3'b000, 0, 0, ST_STAB);
        push_exp(8, 3'b000, 0, 0, ST_WAIT);
        push_sequence(7, 0);
        drive_at(6, 1'b0);
        drive_at(7, 1'b1);
        wait_until(26);
        drain();

        // Loss after stage 0 but before stage 1
        do_reset(1'b1);
        push_exp(10, 3'b001, 0, 0, ST_REL);
        push_exp(12, 3'b001, 0, 0, ST_REL);
        push_exp(13, 3'b000, 0, 1, ST_WAIT);
        push_exp(14, 3'b000, 0, 1, ST_WAIT);
        push_exp(20, 3'b000, 0, 1, ST_WAIT);
        push_exp(30, 3'b000, 0, 1, ST_WAIT);
        drive_at(11, 1'b0);
        wait_until(31);
        drain();

        // Saturation: 256 losses, each just after stage 0 releases
        do_reset(1'b1);
        r = 1;
        for (int i = 1; i <= 256; i++) begin
            if (i == 1 || i >= 254) begin
                push_exp(r + 9,  3'b001, 0, i - 1, ST_REL);
                push_exp(r + 11, 3'b000, 0, (i > 255) ? 255 : i, ST_WAIT);
            end
            drive_at(r + 9, 1'b0);
            drive_at(r + 11, 1'b1);
            r = r + 11;
        end

        // Clear coinciding with a loss keeps the event
        push_exp(r + 9,  3'b001, 0, 255, ST_REL);
        push_exp(r + 11, 3'b000, 0, 1,   ST_WAIT);
        drive_at(r + 9, 1'b0);
        drive_at(r + 11, 1'b1);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        r = r + 11;

        // Clear alone zeroes the count
        push_exp(r + 2, 3'b000, 0, 1, ST_STAB);
        push_exp(r + 3, 3'b000, 0, 0, ST_STAB);
        wait_until(r + 2);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
